// File: rtl/rs_tb_pkg.sv
// Shared definitions for the Reed-Solomon error injector: mode encodings,
// FSM states and the spread-mode LFSR constants.
package rs_tb_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_ZERO   = 2'd1,
    MODE_XOR    = 2'd2,
    MODE_SPREAD = 2'd3
  } rs_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OFFSET = 2'd1,
    ST_INJECT = 2'd2,
    ST_DONE   = 2'd3
  } rs_state_e;

  // x^8 + x^6 + x^5 + x^4 + 1, Fibonacci form: feedback from stages 8,6,5,4
  localparam logic [7:0] LFSR_SEED = 8'h01;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_step(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/rs_err_lfsr.sv
// 8-bit maximal-length LFSR supplying XOR masks for spread-mode injection.
// lfsr_val is the value usable this cycle; a load forces it to the seed
// immediately so the start-cycle symbol already sees the seed.
module rs_err_lfsr
  import rs_tb_pkg::*;
(
  input  logic       clk_out125M,
  input  logic       sys_rst,
  input  logic       load,
  input  logic       en,
  output logic [7:0] lfsr_val
);

  logic [7:0] lfsr_reg;
  logic [7:0] lfsr_next;

  // Current value (seed on load) and its successor when a mask is consumed
  always_comb begin
    lfsr_val  = load ? LFSR_SEED : lfsr_reg;
    lfsr_next = en ? lfsr_step(lfsr_val) : lfsr_val;
  end

  // State register, reseeded on reset
  always_ff @(posedge clk_out125M) begin
    if (sys_rst) begin
      lfsr_reg <= LFSR_SEED;
    end else begin
      lfsr_reg <= lfsr_next;
    end
  end

endmodule

// File: rtl/rs_err_injector.sv
// Symbol-stream error injector for Reed-Solomon decoder testing. Skips a
// configurable offset, then corrupts a chosen number of symbols in each
// codeword (burst-zero, burst-xor or LFSR-spread), with one cycle latency.
module rs_err_injector
  import rs_tb_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int CW_LEN  = 255,
  parameter int MAX_ERR = 16,
  parameter int STRIDE  = 16
) (
  input  logic                         clk_out125M,
  input  logic                         sys_rst,
  input  logic [DATA_W-1:0]            din,
  input  logic                         din_sync,
  input  logic [1:0]                   cfg_mode,
  input  logic [15:0]                  cfg_offset,
  input  logic [$clog2(MAX_ERR+1)-1:0] cfg_err_per_cw,
  input  logic [15:0]                  cfg_num_cw,
  input  logic [DATA_W-1:0]            cfg_xor_pat,
  output logic [DATA_W-1:0]            dout,
  output logic                         dout_sync,
  output logic                         err_flag,
  output logic [31:0]                  inj_count,
  output logic                         done
);

  localparam int ERR_W = $clog2(MAX_ERR + 1);
  localparam int SYM_W = (CW_LEN > 1) ? $clog2(CW_LEN) : 1;
  localparam int STR_W = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam int K_W   = SYM_W + 1;

  // Latched configuration (error count stored already clamped)
  rs_state_e          state_reg;
  logic               prev_sync_reg;
  rs_mode_e           mode_reg;
  logic [15:0]        offset_reg;
  logic [ERR_W-1:0]   err_reg;
  logic [15:0]        num_cw_reg;
  logic [DATA_W-1:0]  xor_pat_reg;

  // Position counters; stride_reg/k_reg track sym_idx = k*STRIDE + stride
  logic [SYM_W-1:0]   sym_idx_reg;
  logic [STR_W-1:0]   stride_reg;
  logic [K_W-1:0]     k_reg;
  logic [15:0]        cw_cnt_reg;
  logic [15:0]        off_cnt_reg;

  logic [DATA_W-1:0]  dout_reg;
  logic               dout_sync_reg;
  logic               err_flag_reg;
  logic [31:0]        inj_count_reg;
  logic               done_reg;

  // Effective view of this cycle: on the start cycle the raw cfg inputs and
  // zeroed counters apply, because the latches only update at the clock edge.
  logic               start;
  rs_mode_e           cur_mode;
  logic [15:0]        cur_offset;
  logic [ERR_W-1:0]   cur_e;
  logic [15:0]        cur_num_cw;
  logic [DATA_W-1:0]  cur_pat;
  logic [SYM_W-1:0]   cur_sym;
  logic [STR_W-1:0]   cur_stride;
  logic [K_W-1:0]     cur_k;
  logic [15:0]        cur_cw;
  logic [15:0]        cw_next;
  logic               in_inject;
  logic               hit;
  logic               corrupt;
  logic [DATA_W-1:0]  corrupt_val;
  logic [7:0]         lfsr_val;
  logic [DATA_W-1:0]  lfsr_ext;

  rs_err_lfsr u_lfsr (
    .clk_out125M (clk_out125M),
    .sys_rst     (sys_rst),
    .load        (start),
    .en          (corrupt && (cur_mode == MODE_SPREAD)),
    .lfsr_val    (lfsr_val)
  );

  // Resolve the active configuration and decide whether this symbol is hit
  always_comb begin
    start      = din_sync && !prev_sync_reg;
    cur_mode   = start ? rs_mode_e'(cfg_mode) : mode_reg;
    cur_offset = start ? cfg_offset : offset_reg;
    cur_e      = start ? ((cfg_err_per_cw > ERR_W'(MAX_ERR)) ? ERR_W'(MAX_ERR) : cfg_err_per_cw)
                       : err_reg;
    cur_num_cw = start ? cfg_num_cw : num_cw_reg;
    cur_pat    = start ? cfg_xor_pat : xor_pat_reg;
    cur_sym    = start ? '0 : sym_idx_reg;
    cur_stride = start ? '0 : stride_reg;
    cur_k      = start ? '0 : k_reg;
    cur_cw     = start ? '0 : cw_cnt_reg;
    cw_next    = cur_cw + 16'd1;
    lfsr_ext   = DATA_W'(lfsr_val);

    in_inject  = din_sync && ((start && (cur_offset == 16'd0)) ||
                              (!start && (state_reg == ST_INJECT)));

    hit = 1'b0;
    case (cur_mode)
      MODE_ZERO, MODE_XOR: hit = (16'(cur_sym) < 16'(cur_e));
      MODE_SPREAD:         hit = (cur_stride == '0) && (16'(cur_k) < 16'(cur_e));
      default:             hit = 1'b0;
    endcase
    corrupt = in_inject && hit;

    corrupt_val = din;
    case (cur_mode)
      MODE_ZERO:   corrupt_val = '0;
      MODE_XOR:    corrupt_val = din ^ cur_pat;
      MODE_SPREAD: corrupt_val = din ^ lfsr_ext;
      default:     corrupt_val = din;
    endcase
  end

  // FSM, counters, cfg latch and registered outputs
  always_ff @(posedge clk_out125M) begin
    if (sys_rst) begin
      state_reg     <= ST_IDLE;
      prev_sync_reg <= 1'b0;
      mode_reg      <= MODE_OFF;
      offset_reg    <= '0;
      err_reg       <= '0;
      num_cw_reg    <= '0;
      xor_pat_reg   <= '0;
      sym_idx_reg   <= '0;
      stride_reg    <= '0;
      k_reg         <= '0;
      cw_cnt_reg    <= '0;
      off_cnt_reg   <= '0;
      dout_reg      <= '0;
      dout_sync_reg <= 1'b0;
      err_flag_reg  <= 1'b0;
      inj_count_reg <= '0;
      done_reg      <= 1'b0;
    end else begin
      prev_sync_reg <= din_sync;
      dout_sync_reg <= din_sync;
      err_flag_reg  <= corrupt;
      dout_reg      <= corrupt ? corrupt_val : din;

      if (!din_sync) begin
        // Frame gap: abandon the run, keep inj_count for inspection
        state_reg   <= ST_IDLE;
        sym_idx_reg <= '0;
        stride_reg  <= '0;
        k_reg       <= '0;
        cw_cnt_reg  <= '0;
        off_cnt_reg <= '0;
        done_reg    <= 1'b0;
      end else begin
        if (start) begin
          mode_reg      <= cur_mode;
          offset_reg    <= cur_offset;
          err_reg       <= cur_e;
          num_cw_reg    <= cur_num_cw;
          xor_pat_reg   <= cur_pat;
          inj_count_reg <= corrupt ? 32'd1 : 32'd0;
          done_reg      <= 1'b0;
        end else if (corrupt && (inj_count_reg != 32'hFFFF_FFFF)) begin
          inj_count_reg <= inj_count_reg + 32'd1;
        end

        if (in_inject) begin
          if (cur_sym == SYM_W'(CW_LEN - 1)) begin
            sym_idx_reg <= '0;
            stride_reg  <= '0;
            k_reg       <= '0;
            cw_cnt_reg  <= cw_next;
            if ((cur_num_cw != 16'd0) && (cw_next == cur_num_cw)) begin
              state_reg <= ST_DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= ST_INJECT;
            end
          end else begin
            sym_idx_reg <= cur_sym + SYM_W'(1);
            state_reg   <= ST_INJECT;
            if (cur_stride == STR_W'(STRIDE - 1)) begin
              stride_reg <= '0;
              k_reg      <= cur_k + K_W'(1);
            end else begin
              stride_reg <= cur_stride + STR_W'(1);
            end
          end
        end else if (start) begin
          // Start symbol is offset symbol 0; offset 1 means the next is cw 0
          sym_idx_reg <= '0;
          stride_reg  <= '0;
          k_reg       <= '0;
          cw_cnt_reg  <= '0;
          if (cur_offset == 16'd1) begin
            state_reg <= ST_INJECT;
          end else begin
            state_reg   <= ST_OFFSET;
            off_cnt_reg <= 16'd1;
          end
        end else if (state_reg == ST_OFFSET) begin
          if ((off_cnt_reg + 16'd1) == offset_reg) begin
            state_reg   <= ST_INJECT;
            off_cnt_reg <= '0;
          end else begin
            off_cnt_reg <= off_cnt_reg + 16'd1;
          end
        end
      end
    end
  end

  assign dout      = dout_reg;
  assign dout_sync = dout_sync_reg;
  assign err_flag  = err_flag_reg;
  assign inj_count = inj_count_reg;
  assign done      = done_reg;

endmodule
